// File: rtl/block_xfer_seq_if.sv
// Handshake/bus bundle between the block-transfer sequencer, the main FSM,
// the register file and memory.
interface block_xfer_seq_if;
  logic        start;
  logic        is_load;
  logic        up;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        busy;
  logic        done;
  logic [31:0] new_base;
  logic [3:0]  rf_read_reg;
  logic [31:0] rf_read_data;
  logic        rf_write;
  logic [3:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // master is the sequencer itself; slave is the FSM/regfile/memory side.
  modport master (
    input  start, is_load, up, reg_list, base_addr,
    input  rf_read_data, mem_ready, mem_rdata,
    output busy, done, new_base,
    output rf_read_reg, rf_write, rf_write_reg, rf_write_data,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output start, is_load, up, reg_list, base_addr,
    output rf_read_data, mem_ready, mem_rdata,
    input  busy, done, new_base,
    input  rf_read_reg, rf_write, rf_write_reg, rf_write_data,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/block_xfer_seq.sv
// LDM/STM sequencer: walks a 16-bit register list one memory beat per register,
// driving the register file ports and producing the written-back base address.
module block_xfer_seq #(
  parameter int WORD_BYTES = 4
) (
  input logic             clk,
  input logic             rst,
  block_xfer_seq_if.master bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      stateReg;
  logic        busyReg;
  logic        doneReg;
  logic        memReqReg;
  logic        memWeReg;
  logic        isLoadReg;
  logic [31:0] memAddrReg;
  logic [31:0] newBaseReg;
  logic [15:0] pendingReg;

  logic [4:0]  listCnt;
  logic [31:0] span;
  logic [3:0]  curReg;
  logic [15:0] pendingNext;
  logic        beatDone;

  always_comb begin
    listCnt = '0;
    for (int i = 0; i < 16; i++) begin
      listCnt = listCnt + 5'(bus.reg_list[i]);
    end
  end

  assign span = 32'(WORD_BYTES) * 32'(listCnt);

  // Lowest pending register goes first, so registers map to ascending addresses.
  always_comb begin
    curReg = '0;
    for (int i = 15; i >= 0; i--) begin
      if (pendingReg[i]) curReg = 4'(i);
    end
  end

  assign pendingNext = pendingReg & ~(16'd1 << curReg);
  assign beatDone    = memReqReg & bus.mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg   <= IDLE;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
      memReqReg  <= 1'b0;
      memWeReg   <= 1'b0;
      isLoadReg  <= 1'b0;
      memAddrReg <= '0;
      newBaseReg <= '0;
      pendingReg <= '0;
    end else begin
      unique case (stateReg)
        IDLE: begin
          if (bus.start) begin
            busyReg    <= 1'b1;
            // span is zero for an empty list, so new_base degenerates to base.
            newBaseReg <= bus.up ? bus.base_addr + span : bus.base_addr - span;
            if (bus.reg_list != 16'd0) begin
              stateReg   <= XFER;
              memReqReg  <= 1'b1;
              memWeReg   <= ~bus.is_load;
              isLoadReg  <= bus.is_load;
              pendingReg <= bus.reg_list;
              memAddrReg <= bus.up ? bus.base_addr : bus.base_addr - span;
            end else begin
              stateReg <= DONE;
              doneReg  <= 1'b1;
            end
          end
        end
        XFER: begin
          if (beatDone) begin
            pendingReg <= pendingNext;
            memAddrReg <= memAddrReg + 32'(WORD_BYTES);
            if (pendingNext == 16'd0) begin
              stateReg  <= DONE;
              memReqReg <= 1'b0;
              memWeReg  <= 1'b0;
              doneReg   <= 1'b1;
            end
          end
        end
        DONE: begin
          stateReg <= IDLE;
          doneReg  <= 1'b0;
          busyReg  <= 1'b0;
        end
        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = busyReg;
  assign bus.done          = doneReg;
  assign bus.new_base      = newBaseReg;
  assign bus.mem_req       = memReqReg;
  assign bus.mem_we        = memWeReg;
  assign bus.mem_addr      = memAddrReg;
  assign bus.mem_wdata     = bus.rf_read_data;
  assign bus.rf_read_reg   = curReg;
  // Load data goes straight into the register file in the beat's own cycle.
  assign bus.rf_write      = isLoadReg & beatDone;
  assign bus.rf_write_reg  = curReg;
  assign bus.rf_write_data = bus.mem_rdata;

endmodule

// File: tb/tb_block_xfer_seq.sv
// Scoreboard bench for block_xfer_seq: stimulus queues expected beats and done
// events; a negedge monitor pops and compares them against the DUT.
module tb_block_xfer_seq;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  rg;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    int          cyc;
    logic [31:0] nb;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic preload = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   stallsWanted = 0;
  int   stallCnt;
  int   beatNum = 0;

  logic [31:0] rf [16];
  logic [31:0] rfExp [16];
  logic [31:0] memArr [256];

  beat_t beatQ[$];
  done_t doneQ[$];
  beat_t curBeat;
  done_t curDone;

  logic        prevStalled = 1'b0;
  logic [31:0] prevAddr;
  logic [31:0] prevWdata;

  block_xfer_seq_if ifc();

  block_xfer_seq #(.WORD_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign ifc.rf_read_data = rf[ifc.rf_read_reg];
  assign ifc.mem_rdata    = memArr[ifc.mem_addr[9:2]];
  assign ifc.mem_ready    = (stallCnt == stallsWanted);

  always @(posedge clk or negedge rst) begin
    if (!rst) stallCnt <= 0;
    else if (ifc.mem_req) stallCnt <= ifc.mem_ready ? 0 : stallCnt + 1;
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'(i) * 32'h11;
    end else if (ifc.rf_write) begin
      rf[ifc.rf_write_reg] <= ifc.rf_write_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: compares every completed beat and done pulse with the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (ifc.mem_req) begin
        if (prevStalled) begin
          chk("stall_addr_stable", ifc.mem_addr, prevAddr);
          chk("stall_wdata_stable", ifc.mem_wdata, prevWdata);
        end
        if (!ifc.mem_ready) chk("stall_rf_write", 32'(ifc.rf_write), 32'd0);
        prevStalled = !ifc.mem_ready;
        prevAddr    = ifc.mem_addr;
        prevWdata   = ifc.mem_wdata;
      end else begin
        prevStalled = 1'b0;
      end
      if (ifc.mem_req && ifc.mem_ready) begin
        beatNum++;
        if (beatQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got addr %h required no beat", ifc.mem_addr);
        end else begin
          curBeat = beatQ.pop_front();
          $display("beat cyc=%0d addr=%h we=%0d wdata=%h rf_write=%0d reg=%0d rdata=%h",
                   cyc, ifc.mem_addr, ifc.mem_we, ifc.mem_wdata, ifc.rf_write,
                   ifc.rf_write_reg, ifc.rf_write_data);
          chk("beat_cycle", 32'(cyc), 32'(curBeat.cyc));
          chk("beat_addr", ifc.mem_addr, curBeat.addr);
          chk("beat_we", 32'(ifc.mem_we), 32'(curBeat.we));
          if (curBeat.we) begin
            chk("store_wdata", ifc.mem_wdata, curBeat.data);
            chk("store_rf_write", 32'(ifc.rf_write), 32'd0);
          end else begin
            chk("load_rf_write", 32'(ifc.rf_write), 32'd1);
            chk("load_rf_reg", 32'(ifc.rf_write_reg), 32'(curBeat.rg));
            chk("load_rf_data", ifc.rf_write_data, curBeat.data);
          end
        end
      end
      if (ifc.done) begin
        if (doneQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done at cyc %0d required none", cyc);
        end else begin
          curDone = doneQ.pop_front();
          $display("done cyc=%0d new_base=%h busy=%0d", cyc, ifc.new_base, ifc.busy);
          chk("done_cycle", 32'(cyc), 32'(curDone.cyc));
          chk("new_base", ifc.new_base, curDone.nb);
          chk("busy_at_done", 32'(ifc.busy), 32'd1);
        end
      end
    end
  end

  // Pushes expected beats/done, pulses start; returns in the first beat cycle.
  task automatic issueStart(input logic ld, input logic upD, input logic [15:0] list,
                            input logic [31:0] base, input int stalls,
                            input logic [31:0] expNb);
    int n = 0;
    int k = 0;
    int tEdge;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) if (list[i]) n++;
    @(negedge clk);
    stallsWanted = stalls;
    tEdge = cyc + 1;
    a = upD ? base : base - 32'(4 * n);
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        beat_t b;
        b.cyc  = tEdge + (k + 1) * (stalls + 1) - 1;
        b.we   = !ld;
        b.addr = a;
        b.rg   = 4'(i);
        b.data = ld ? memArr[a[9:2]] : rfExp[i];
        if (ld) rfExp[i] = b.data;
        beatQ.push_back(b);
        a = a + 32'd4;
        k++;
      end
    end
    doneQ.push_back('{tEdge + n * (stalls + 1), expNb});
    ifc.start     = 1'b1;
    ifc.is_load   = ld;
    ifc.up        = upD;
    ifc.reg_list  = list;
    ifc.base_addr = base;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    for (int i = 0; i < 300; i++) begin
      if (ifc.done) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got no done required done within 300 cycles", name);
  endtask

  initial begin
    ifc.start     = 1'b0;
    ifc.is_load   = 1'b0;
    ifc.up        = 1'b1;
    ifc.reg_list  = 16'd0;
    ifc.base_addr = 32'd0;
    for (int i = 0; i < 256; i++) memArr[i] = 32'd0;
    memArr[8'h7E] = 32'hA;
    memArr[8'h7F] = 32'hB;
    for (int i = 0; i < 4; i++) memArr[8'hC0 + i] = 32'h1000 + 32'(i);
    for (int i = 0; i < 16; i++) rfExp[i] = 32'(i) * 32'h11;
    preload = 1'b1;
    repeat (3) @(negedge clk);
    preload = 1'b0;

    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_mem_req", 32'(ifc.mem_req), 32'd0);
    chk("rst_mem_we", 32'(ifc.mem_we), 32'd0);
    chk("rst_rf_write", 32'(ifc.rf_write), 32'd0);
    chk("rst_new_base", ifc.new_base, 32'd0);
    chk("rst_mem_addr", ifc.mem_addr, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // STM ascending, zero wait
    issueStart(1'b0, 1'b1, 16'h0016, 32'h100, 0, 32'h10C);
    chk("busy_in_xfer", 32'(ifc.busy), 32'd1);
    waitDone("stm_up");

    // LDM descending
    issueStart(1'b1, 1'b0, 16'h8001, 32'h200, 0, 32'h1F8);
    waitDone("ldm_down");
    chk("ldm_r0", rf[0], 32'hA);
    chk("ldm_r15", rf[15], 32'hB);

    // STM with two wait states before each beat
    issueStart(1'b0, 1'b1, 16'h0016, 32'h100, 2, 32'h10C);
    waitDone("stm_wait");

    // Empty list
    issueStart(1'b0, 1'b1, 16'h0000, 32'h444, 0, 32'h444);
    waitDone("empty");
    @(negedge clk);
    chk("busy_after_done", 32'(ifc.busy), 32'd0);
    chk("new_base_held", ifc.new_base, 32'h444);

    // Full list with address wrap
    issueStart(1'b0, 1'b1, 16'hFFFF, 32'hFFFFFFC0, 0, 32'h0);
    waitDone("wrap");

    // Start while busy must be ignored
    issueStart(1'b0, 1'b1, 16'h0016, 32'h100, 0, 32'h10C);
    ifc.start     = 1'b1;
    ifc.is_load   = 1'b1;
    ifc.up        = 1'b0;
    ifc.reg_list  = 16'h00E0;
    ifc.base_addr = 32'h300;
    @(negedge clk);
    ifc.start = 1'b0;
    waitDone("busy_start");

    // Reset during beat 2 of a 4-register LDM
    beatNum = 0;
    issueStart(1'b1, 1'b1, 16'h00F0, 32'h300, 0, 32'h310);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(ifc.mem_req), 32'd0);
    chk("midrst_busy", 32'(ifc.busy), 32'd0);
    chk("midrst_rf_write", 32'(ifc.rf_write), 32'd0);
    chk("midrst_mem_addr", ifc.mem_addr, 32'd0);
    chk("midrst_new_base", ifc.new_base, 32'd0);
    beatQ.delete();
    doneQ.delete();
    rfExp[5] = 32'h55;
    rfExp[6] = 32'h66;
    rfExp[7] = 32'h77;
    @(negedge clk);
    chk("midrst_beats", 32'(beatNum), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_r4", rf[4], 32'h1000);
    chk("midrst_r5", rf[5], 32'h55);
    chk("midrst_r6", rf[6], 32'h66);
    chk("midrst_r7", rf[7], 32'h77);

    // Fresh start after reset
    issueStart(1'b1, 1'b1, 16'h00F0, 32'h300, 0, 32'h310);
    waitDone("after_rst");
    chk("fresh_r7", rf[7], 32'h1003);
    chk("fresh_r5", rf[5], 32'h1001);

    repeat (3) @(negedge clk);
    chk("beatq_empty", 32'(beatQ.size()), 32'd0);
    chk("doneq_empty", 32'(doneQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
